btn_debounce: RTL

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/debounce_pkg.sv | 16 +
 rtl/sync_ff.sv | 25 ++
 rtl/btn_debounce.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types and default constants for the push-button debouncer.
// The state enum lives here so that other blocks can decode the FSM state.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } btn_state_e;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_WIDTH_DEF   = 20;
    localparam int HOLD_WIDTH_DEF  = 26;

endpackage

// File: rtl/sync_ff.sv
// Generic multi-flop synchronizer for a single asynchronous level.
// Intended for reuse on any asynchronous input; STAGES must be at least 2.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw level through the flop chain; the last flop is the safe copy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchronizer, stability-window FSM, edge pulses.
// Optional long-press detection is compiled in with `define BTN_DEBOUNCE_HOLD_EN;
// without it hold_o is tied low and no hold counter exists.
// A new level must be seen on btn_sync for 2**CNT_WIDTH consecutive cycles
// (entry cycle included) before btn_o follows it.
module btn_debounce
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int HOLD_WIDTH  = HOLD_WIDTH_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic btn_o,
    output logic rise_o,
    output logic fall_o,
    output logic hold_o
);

    // Last count value seen before commit: the entry cycle plus
    // 2**CNT_WIDTH-1 counted cycles make up the full stability window,
    // so the counter would reach 2**CNT_WIDTH-1 on the commit edge and never wraps.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = {{(CNT_WIDTH-1){1'b1}}, 1'b0};

    // Elaboration-time guards on the parameter ranges.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_sync_stages_check
        $error("btn_debounce: SYNC_STAGES must be in 2..4");
    end
    if (CNT_WIDTH < 2) begin : g_cnt_width_check
        $error("btn_debounce: CNT_WIDTH must be at least 2");
    end
    if (HOLD_WIDTH < 1) begin : g_hold_width_check
        $error("btn_debounce: HOLD_WIDTH must be at least 1");
    end

    logic                 btn_sync;
    btn_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 btn_q, btn_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (btn_i),
        .q_o    (btn_sync)
    );

    // Register the FSM state, the stability counter and the registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            btn_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            btn_q   <= btn_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next-state logic: wait out the stability window, abandon it on any reversion.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        btn_d   = btn_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (btn_sync) begin
                    state_d = ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (!btn_sync) begin
                    state_d = ST_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    btn_d   = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_HIGH: begin
                if (!btn_sync) begin
                    state_d = ST_WAIT_LOW;
                end
            end
            ST_WAIT_LOW: begin
                if (btn_sync) begin
                    state_d = ST_HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                    btn_d   = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_LOW;
            end
        endcase
    end

    assign btn_o  = btn_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

`ifdef BTN_DEBOUNCE_HOLD_EN
    localparam logic [HOLD_WIDTH-1:0] HOLD_MAX = '1;

    logic [HOLD_WIDTH-1:0] hold_cnt_q;
    logic                  hold_done_q;
    logic                  hold_q;

    // Count time spent in ST_HIGH; fire once per press when the count saturates.
    // The fired flag survives release bounces and is only cleared once the button is low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_cnt_q  <= '0;
            hold_done_q <= 1'b0;
            hold_q      <= 1'b0;
        end else begin
            hold_q <= 1'b0;
            if (state_q == ST_HIGH) begin
                if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_q <= hold_cnt_q + HOLD_WIDTH'(1);
                end else if (!hold_done_q) begin
                    hold_q      <= 1'b1;
                    hold_done_q <= 1'b1;
                end
            end else begin
                hold_cnt_q <= '0;
            end
            if (state_q == ST_LOW || state_q == ST_WAIT_HIGH) begin
                hold_done_q <= 1'b0;
            end
        end
    end

    assign hold_o = hold_q;
`else
    assign hold_o = 1'b0;
`endif

endmodule
